// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
//   Mode encoding : MODE_HOLD / MODE_SHR / MODE_SHL / MODE_LOAD (2-bit).
//   usr_cw(n)     : shift-counter width, max(1, $clog2(n)).
package usr_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Counter width; a 2-bit register still needs one counter bit.
   function automatic int usr_cw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/usr_frame_counter.sv
// Modulo-N shift counter with a registered frame-boundary pulse.
//   Inputs : clk, rst (sync, active-high), clr (restart frame), inc (one shift).
//   Outputs: cnt (shifts so far in the frame), frame_done (1-cycle pulse
//            registered on the edge that completes N shifts).
module usr_frame_counter
   import usr_pkg::*;
#(
   parameter  int N  = 8,
   localparam int CW = usr_cw(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          frame_done
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [CW-1:0] r_cnt;
   logic          r_frame_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_frame_done <= 1'b0;
      end else if (clr) begin
         // A load discards any partial frame.
         r_cnt        <= '0;
         r_frame_done <= 1'b0;
      end else if (inc) begin
         // Wrap at N-1 explicitly so non-power-of-two widths never
         // reach the unused upper counter codes.
         if (r_cnt == LAST) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b1;
         end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_frame_done <= 1'b0;
         end
      end else begin
         // Hold keeps the count but the pulse lasts only one cycle.
         r_frame_done <= 1'b0;
      end
   end

   assign cnt        = r_cnt;
   assign frame_done = r_frame_done;

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register: hold, shift right/left (rotate or serial
// fill) and parallel load, with a modulo-N shift counter for framing.
//   Inputs : clk, rst (sync, active-high), en, mode[1:0], rot, sin, D[N-1:0].
//   Outputs: Q, sout_r (=Q[0]), sout_l (=Q[N-1]), cnt, frame_done and, when
//            USR_PARITY_EN is defined, q_parity (registered ^Q).
module universal_shift_register
   import usr_pkg::*;
#(
   parameter  int N  = 8,
   localparam int CW = usr_cw(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic          rot,
   input  logic          sin,
   input  logic [N-1:0]  D,
   output logic [N-1:0]  Q,
   output logic          sout_r,
   output logic          sout_l,
   output logic [CW-1:0] cnt,
   output logic          frame_done
`ifdef USR_PARITY_EN
   ,
   output logic          q_parity
`endif
);

   logic [N-1:0] r_q;
   logic [N-1:0] w_q_next;
   logic         w_shift;
   logic         w_load;

   assign w_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
   assign w_load  = en && (mode == MODE_LOAD);

   always_comb begin
      w_q_next = r_q;
      if (en) begin
         case (mode)
            MODE_SHR:  w_q_next = {(rot ? r_q[0]   : sin), r_q[N-1:1]};
            MODE_SHL:  w_q_next = {r_q[N-2:0], (rot ? r_q[N-1] : sin)};
            MODE_LOAD: w_q_next = D;
            default:   w_q_next = r_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_q <= '0;
      else     r_q <= w_q_next;
   end

`ifdef USR_PARITY_EN
   logic r_parity;

   // Computed from the next value so parity lands on the same edge as Q.
   always_ff @(posedge clk) begin
      if (rst) r_parity <= 1'b0;
      else     r_parity <= ^w_q_next;
   end

   assign q_parity = r_parity;
`endif

   usr_frame_counter #(.N(N)) u_frame_counter (
      .clk        (clk),
      .rst        (rst),
      .clr        (w_load),
      .inc        (w_shift),
      .cnt        (cnt),
      .frame_done (frame_done)
   );

   assign Q      = r_q;
   assign sout_r = r_q[0];
   assign sout_l = r_q[N-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (N=8 main instance, N=5 wrap
// instance). Expected register/counter values come from a small behavioural
// model and are queued at drive time, then popped and compared after the edge.
module tb_universal_shift_register;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst, en, rot, sin;
   logic [1:0]   mode;
   logic [N-1:0] D;
   logic [N-1:0] Q;
   logic         sout_r, sout_l, frame_done;
   logic [2:0]   cnt;

   logic         b_rst, b_en, b_rot, b_sin;
   logic [1:0]   b_mode;
   logic [4:0]   b_D, b_Q;
   logic         b_sout_r, b_sout_l, b_frame_done;
   logic [2:0]   b_cnt;

`ifdef USR_PARITY_EN
   logic q_parity, b_q_parity;
`endif

   always #5 clk = ~clk;

   universal_shift_register #(.N(N)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .sin(sin), .D(D),
      .Q(Q), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .frame_done(frame_done)
`ifdef USR_PARITY_EN
      , .q_parity(q_parity)
`endif
   );

   universal_shift_register #(.N(5)) dut5 (
      .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .rot(b_rot), .sin(b_sin),
      .D(b_D), .Q(b_Q), .sout_r(b_sout_r), .sout_l(b_sout_l), .cnt(b_cnt),
      .frame_done(b_frame_done)
`ifdef USR_PARITY_EN
      , .q_parity(b_q_parity)
`endif
   );

   typedef struct packed {
      logic [N-1:0] q;
      logic [2:0]   cnt;
      logic         fd;
   } exp_t;

   exp_t         sb[$];
   logic [N-1:0] m_q;
   logic [2:0]   m_cnt;
   int           errors = 0;
   int           checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on the N=8 instance, predict, then compare after the edge.
   task automatic step(input string tag, input logic r, input logic e,
                       input logic [1:0] m, input logic ro, input logic s,
                       input logic [N-1:0] d);
      exp_t x;
      logic fd;
      rst = r; en = e; mode = m; rot = ro; sin = s; D = d;
      fd = 1'b0;
      if (r) begin
         m_q = '0; m_cnt = '0;
      end else if (e && m == 2'b11) begin
         m_q = d; m_cnt = '0;
      end else if (e && (m == 2'b01 || m == 2'b10)) begin
         if (m == 2'b01) m_q = {(ro ? m_q[0] : s), m_q[N-1:1]};
         else            m_q = {m_q[N-2:0], (ro ? m_q[N-1] : s)};
         if (m_cnt == 3'(N - 1)) begin m_cnt = '0; fd = 1'b1; end
         else                    m_cnt = m_cnt + 3'd1;
      end
      sb.push_back('{q: m_q, cnt: m_cnt, fd: fd});
      @(posedge clk); #1;
      x = sb.pop_front();
      chk({tag, ".Q"},      32'(Q),          32'(x.q));
      chk({tag, ".cnt"},    32'(cnt),        32'(x.cnt));
      chk({tag, ".fd"},     32'(frame_done), 32'(x.fd));
      chk({tag, ".sout_r"}, 32'(sout_r),     32'(x.q[0]));
      chk({tag, ".sout_l"}, 32'(sout_l),     32'(x.q[N-1]));
`ifdef USR_PARITY_EN
      chk({tag, ".par"},    32'(q_parity),   32'(^x.q));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] sipo_bits;
      logic [N-1:0] piso_pat;
      logic [N-1:0] q_before;
      logic [2:0]   c_before;

      rst = 1'b1; en = 1'b0; mode = 2'b00; rot = 1'b0; sin = 1'b0; D = '0;
      b_rst = 1'b1; b_en = 1'b0; b_mode = 2'b00; b_rot = 1'b0; b_sin = 1'b0; b_D = '0;
      m_q = '0; m_cnt = '0;

      // Reset state.
      step("reset", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, '0);
      chk("reset.Q_const", 32'(Q), 32'h0);

      // Reset mid-frame, with a load requested in the same cycle.
      step("ld_a5", 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
      step("sh1",   1'b0, 1'b1, 2'b01, 1'b0, 1'b1, '0);
      step("sh2",   1'b0, 1'b1, 2'b10, 1'b0, 1'b0, '0);
      chk("midframe.cnt2", 32'(cnt), 32'd2);
      step("rst_mid", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);
      chk("rst_mid.Q_const", 32'(Q), 32'h0);
      chk("rst_mid.cnt_const", 32'(cnt), 32'h0);

      // Serial-in, parallel-out: first bit in ends up in Q[0].
      sipo_bits = 8'b0100_1101;   // sin sequence 1,0,1,1,0,0,1,0 read from bit 0 up
      for (int i = 0; i < N; i++)
         step("sipo", 1'b0, 1'b1, 2'b01, 1'b0, sipo_bits[i], '0);
      chk("sipo.Q_const",  32'(Q),          32'h4D);
      chk("sipo.fd_const", 32'(frame_done), 32'h1);

      // Parallel-in, serial-out through sout_l.
      piso_pat = 8'hC3;
      step("ld_c3", 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hC3);
      for (int i = 0; i < N; i++) begin
         chk("piso.sout_l", 32'(sout_l), 32'(piso_pat[N-1-i]));
         step("piso", 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, '0);
      end
      chk("piso.Q_const", 32'(Q), 32'h0);

      // Rotate right: 3 steps then 5 more brings the value back.
      step("ld_81", 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 8'h81);
      for (int i = 0; i < 3; i++) step("rot3", 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, '0);
      chk("rot3.Q_const", 32'(Q), 32'h30);
      for (int i = 0; i < 5; i++) step("rot5", 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, '0);
      chk("rot8.Q_const",  32'(Q),          32'h81);
      chk("rot8.fd_const", 32'(frame_done), 32'h1);

      // Holds (en=0 or mode=00) interleaved with mixed-direction shifts.
      step("ld_5a", 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
      for (int i = 0; i < N; i++) begin
         q_before = Q; c_before = cnt;
         if (i % 2 == 0) step("hold_en0",  1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'hFF);
         else            step("hold_m00",  1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'hFF);
         chk("hold.Q_frozen",   32'(Q),   32'(q_before));
         chk("hold.cnt_frozen", 32'(cnt), 32'(c_before));
         step("hold_sh", 1'b0, 1'b1, (i % 3 == 0) ? 2'b10 : 2'b01, i[0], i[1], '0);
         chk("hold_sh.fd_const", 32'(frame_done), (i == N - 1) ? 32'h1 : 32'h0);
      end

`ifdef USR_PARITY_EN
      step("par_ld07", 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h07);
      chk("par07.const", 32'(q_parity), 32'h1);
      step("par_shr", 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, '0);
      chk("par03.Q_const", 32'(Q), 32'h03);
      chk("par03.const", 32'(q_parity), 32'h0);
`endif

      // N=5 instance: cnt wraps 4 -> 0, holds in between do not disturb it.
      @(posedge clk); #1;
      b_rst = 1'b0; b_en = 1'b1; b_mode = 2'b11; b_D = 5'h15;
      @(posedge clk); #1;
      chk("n5.load_Q", 32'(b_Q), 32'h15);
      for (int i = 0; i < 10; i++) begin
         b_en = 1'b1; b_mode = 2'b01; b_rot = 1'b1;
         @(posedge clk); #1;
         chk("n5.cnt", 32'(b_cnt), 32'((i + 1) % 5));
         chk("n5.fd",  32'(b_frame_done), ((i + 1) % 5 == 0) ? 32'h1 : 32'h0);
         b_en = 1'b0;
         @(posedge clk); #1;
         chk("n5.hold_cnt", 32'(b_cnt), 32'((i + 1) % 5));
         chk("n5.hold_fd",  32'(b_frame_done), 32'h0);
      end
      chk("n5.rot10_Q", 32'(b_Q), 32'h15);

      chk("sb.empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
